// File: rtl/hpdmc_ddr16_wrpath.sv
// hpdmc_ddr16_wrpath
// -------------------
// Write-direction datapath for the DDR16 SDRAM PHY. It takes one 2*DQ_WIDTH
// word per sys_clk from the controller and splits it into rising-edge (d0)
// and falling-edge (d1) halves for the external ODDR2 primitives on DQ, DM
// and DQS. It also sequences the DQ/DQS output enables: write latency, then a
// one-cycle DQS preamble, BURST_WORDS data beats, and a one-cycle postamble.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start                write command issued to the SDRAM this cycle
//   busy                 high whenever the sequencer is not idle
//   overrun              one-cycle pulse when a start was ignored
//   wr_data, wr_mask     write word / byte masks (upper half -> rising edge)
//   wr_ack               wr_data/wr_mask are sampled at this clock edge
//   dq_d0, dq_d1         DQ halves to ODDR2
//   dm_d0, dm_d1         DM halves to ODDR2 (1 = masked)
//   dqs_d0, dqs_d1       DQS levels to ODDR2
//   dq_oe, dqs_oe        tristate enables (1 = drive)
//
// Handshake: wr_ack is a pure acknowledge with no back-pressure. Whenever
// wr_ack is high the upstream must present a valid word on wr_data/wr_mask;
// that word is captured at the next rising edge and is driven on the pins in
// the following cycle. The upstream cannot stall the burst.
//
// Every output is either a register or a decode of registered state; no
// input reaches an output combinationally.

module hpdmc_ddr16_wrpath #(
    parameter int DQ_WIDTH      = 16,
    parameter int BURST_WORDS   = 4,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      overrun,
    input  logic [2*DQ_WIDTH-1:0]     wr_data,
    input  logic [2*DQ_WIDTH/8-1:0]   wr_mask,
    output logic                      wr_ack,
    output logic [DQ_WIDTH-1:0]       dq_d0,
    output logic [DQ_WIDTH-1:0]       dq_d1,
    output logic [DQ_WIDTH/8-1:0]     dm_d0,
    output logic [DQ_WIDTH/8-1:0]     dm_d1,
    output logic [DQ_WIDTH/8-1:0]     dqs_d0,
    output logic [DQ_WIDTH/8-1:0]     dqs_d1,
    output logic                      dq_oe,
    output logic                      dqs_oe
);

    localparam int NB = DQ_WIDTH / 8;

    // The latency counter is loaded with WRITE_LATENCY-2 so that LAT lasts
    // WRITE_LATENCY-1 cycles and PRE lands exactly WRITE_LATENCY cycles
    // after the accepted start.
    localparam logic [2:0] LAT_INIT  = 3'((WRITE_LATENCY > 1) ? (WRITE_LATENCY - 2) : 0);
    localparam logic [3:0] BEAT_LAST = 4'(BURST_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LAT  = 3'd1,
        S_PRE  = 3'd2,
        S_DATA = 3'd3,
        S_POST = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] lat_cnt;
    logic [2:0] lat_cnt_nx;
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_nx;
    logic       accept;
    logic       ignored;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            lat_cnt  <= lat_cnt_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        lat_cnt_nx  = lat_cnt;
        beat_cnt_nx = beat_cnt;
        accept      = 1'b0;
        ignored     = 1'b0;

        case (state)
            S_IDLE: begin
                accept = start;
            end
            S_LAT: begin
                ignored = start;
                if (lat_cnt == 3'd0) begin
                    state_nx = S_PRE;
                end else begin
                    lat_cnt_nx = lat_cnt - 3'd1;
                end
            end
            S_PRE: begin
                ignored     = start;
                state_nx    = S_DATA;
                beat_cnt_nx = 4'd0;
            end
            S_DATA: begin
                ignored = start;
                if (beat_cnt == BEAT_LAST) begin
                    state_nx = S_POST;
                end else begin
                    beat_cnt_nx = beat_cnt + 4'd1;
                end
            end
            S_POST: begin
                // A start here chains the next burst with no idle gap, so the
                // postamble runs straight into the next preamble or latency.
                state_nx = S_IDLE;
                accept   = start;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (accept) begin
            if (WRITE_LATENCY > 1) begin
                state_nx   = S_LAT;
                lat_cnt_nx = LAT_INIT;
            end else begin
                state_nx   = S_PRE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoded control outputs
    // ------------------------------------------------------------------
    // The word acked in PRE feeds the first DATA beat; the last DATA beat
    // is not acked because its successor cycle is the postamble.
    assign wr_ack = (state == S_PRE) ||
                    ((state == S_DATA) && (beat_cnt != BEAT_LAST));
    assign busy   = (state != S_IDLE);
    assign dq_oe  = (state == S_DATA);
    assign dqs_oe = (state == S_PRE) || (state == S_DATA) || (state == S_POST);

    // DQS toggles high/low within each DATA cycle; in preamble and postamble
    // it is driven low.
    assign dqs_d0 = (state == S_DATA) ? {NB{1'b1}} : {NB{1'b0}};
    assign dqs_d1 = {NB{1'b0}};

    // ------------------------------------------------------------------
    // Data / mask pipeline and overrun flag
    // ------------------------------------------------------------------
    // An acked word always lands in a DATA cycle; any non-acked cycle loads
    // the idle pattern (data 0, all bytes masked).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_d0   <= '0;
            dq_d1   <= '0;
            dm_d0   <= {NB{1'b1}};
            dm_d1   <= {NB{1'b1}};
            overrun <= 1'b0;
        end else begin
            overrun <= ignored;
            if (wr_ack) begin
                dq_d0 <= wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
                dq_d1 <= wr_data[DQ_WIDTH-1:0];
                dm_d0 <= wr_mask[2*NB-1:NB];
                dm_d1 <= wr_mask[NB-1:0];
            end else begin
                dq_d0 <= '0;
                dq_d1 <= '0;
                dm_d0 <= {NB{1'b1}};
                dm_d1 <= {NB{1'b1}};
            end
        end
    end

endmodule

// File: tb/tb_hpdmc_ddr16_wrpath.sv
// tb_hpdmc_ddr16_wrpath
// ---------------------
// Directed bench for hpdmc_ddr16_wrpath. Two instances: one with default
// parameters (WRITE_LATENCY=1) and one with WRITE_LATENCY=3. A data driver
// supplies a word whenever an instance acks and pushes the expected pin
// values into that instance's queue; a monitor pops and compares on every
// DATA cycle and checks the idle pattern otherwise. The main sequence walks
// reset, single burst with masks, back-to-back, overrun, latency and
// mid-burst reset, checking cycle-by-cycle control timing against a small
// offset model.

module tb_hpdmc_ddr16_wrpath;

    localparam int DQ = 16;
    localparam int NB = 2;
    localparam int BW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;   // posedge at 5,15,...; negedge at 10,20,...

    logic rst_n = 1'b1;

    // ---------------- stimulus / DUT signals ----------------
    logic            start   = 1'b0;
    logic            start2  = 1'b0;
    logic [2*DQ-1:0] wr_data = '0;
    logic [2*NB-1:0] wr_mask = '0;

    logic            busy, overrun, wr_ack, dq_oe, dqs_oe;
    logic [DQ-1:0]   dq_d0, dq_d1;
    logic [NB-1:0]   dm_d0, dm_d1, dqs_d0, dqs_d1;

    logic            busy_2, overrun_2, wr_ack_2, dq_oe_2, dqs_oe_2;
    logic [DQ-1:0]   dq_d0_2, dq_d1_2;
    logic [NB-1:0]   dm_d0_2, dm_d1_2, dqs_d0_2, dqs_d1_2;

    hpdmc_ddr16_wrpath #(.DQ_WIDTH(DQ), .BURST_WORDS(BW), .WRITE_LATENCY(1)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .start     (start),
        .busy      (busy),
        .overrun   (overrun),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .wr_ack    (wr_ack),
        .dq_d0     (dq_d0),
        .dq_d1     (dq_d1),
        .dm_d0     (dm_d0),
        .dm_d1     (dm_d1),
        .dqs_d0    (dqs_d0),
        .dqs_d1    (dqs_d1),
        .dq_oe     (dq_oe),
        .dqs_oe    (dqs_oe)
    );

    hpdmc_ddr16_wrpath #(.DQ_WIDTH(DQ), .BURST_WORDS(BW), .WRITE_LATENCY(3)) dut_wl3 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .start     (start2),
        .busy      (busy_2),
        .overrun   (overrun_2),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .wr_ack    (wr_ack_2),
        .dq_d0     (dq_d0_2),
        .dq_d1     (dq_d1_2),
        .dm_d0     (dm_d0_2),
        .dm_d1     (dm_d1_2),
        .dqs_d0    (dqs_d0_2),
        .dqs_d1    (dqs_d1_2),
        .dq_oe     (dq_oe_2),
        .dqs_oe    (dqs_oe_2)
    );

    // ---------------- scoreboard state ----------------
    // Entries are {dq_d0, dq_d1, dm_d0, dm_d1}, i.e. {data_hi, data_lo,
    // mask_hi, mask_lo} of the word that was acked.
    logic [35:0] exp_q[$];
    logic [35:0] exp2_q[$];
    logic [35:0] stim_q[$];   // {wr_data, wr_mask} words queued for the next acks
    bit          mon_en = 1'b0;
    int          total  = 0;
    int          bad    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control timing model: k = cycles since the edge that sampled start.
    task automatic check_timing(input string tag, input int k, input int wl,
                                input logic b, input logic a, input logic qoe,
                                input logic soe, input logic [1:0] s0,
                                input logic [1:0] s1, input logic ov,
                                input logic exp_ov);
        logic       lat, pre, dat, post;
        logic [8:0] obs, exp;
        lat  = (k >= 1) && (k < wl);
        pre  = (k == wl);
        dat  = (k > wl) && (k <= wl + BW);
        post = (k == wl + BW + 1);
        obs  = {b, a, qoe, soe, s0, s1, ov};
        exp  = {lat | pre | dat | post, pre | (dat && (k < wl + BW)), dat,
                pre | dat | post, dat ? 2'b11 : 2'b00, 2'b00, exp_ov};
        check($sformatf("%s_k%0d", tag, k), 64'(obs), 64'(exp));
    endtask

    // ---------------- data driver ----------------
    always @(negedge clk) begin : driver
        logic [35:0] s;
        if (rst_n && (wr_ack === 1'b1 || wr_ack_2 === 1'b1)) begin
            if (stim_q.size() > 0) s = stim_q.pop_front();
            else                   s = {$urandom, 4'($urandom_range(0, 15))};
            wr_data = s[35:4];
            wr_mask = s[3:0];
            if (wr_ack === 1'b1)   exp_q.push_back(s);
            if (wr_ack_2 === 1'b1) exp2_q.push_back(s);
        end else begin
            // Garbage outside ack cycles: it must never reach the pins.
            wr_data = $urandom;
            wr_mask = 4'($urandom_range(0, 15));
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin : monitor1
        logic [35:0] e;
        if (mon_en) begin
            if (dq_oe === 1'b1) begin
                check("beat_available", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'({dq_d0, dq_d1, dm_d0, dm_d1}), 64'(e));
                end
            end else begin
                check("idle_dq_dm", 64'({dq_d0, dq_d1, dm_d0, dm_d1}), 64'({32'h0, 4'hF}));
            end
        end
    end

    always @(negedge clk) begin : monitor2
        logic [35:0] e;
        if (mon_en) begin
            if (dq_oe_2 === 1'b1) begin
                check("wl3_beat_available", 64'(exp2_q.size() != 0), 64'(1));
                if (exp2_q.size() != 0) begin
                    e = exp2_q.pop_front();
                    check("wl3_beat_data", 64'({dq_d0_2, dq_d1_2, dm_d0_2, dm_d1_2}), 64'(e));
                end
            end else begin
                check("wl3_idle_dq_dm", 64'({dq_d0_2, dq_d1_2, dm_d0_2, dm_d1_2}), 64'({32'h0, 4'hF}));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 64'({busy, overrun, wr_ack, dq_oe, dqs_oe}), 64'(0));
        check("rst_dq", 64'({dq_d0, dq_d1}), 64'(0));
        check("rst_dm", 64'({dm_d0, dm_d1}), 64'(4'hF));
        check("rst_dqs", 64'({dqs_d0, dqs_d1}), 64'(0));
        check("rst_wl3_ctrl", 64'({busy_2, wr_ack_2, dq_oe_2, dqs_oe_2}), 64'(0));
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", 64'({busy, dqs_oe, wr_ack}), 64'(0));

        // Single burst with masks (beat 2 masked 4'b1010)
        stim_q.push_back({32'h11112222, 4'b0000});
        stim_q.push_back({32'h33334444, 4'b1010});
        stim_q.push_back({32'h55556666, 4'b0011});
        stim_q.push_back({32'h77778888, 4'b0000});
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_timing("single", k, 1, busy, wr_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, overrun, 1'b0);
            if (k == 2) check("first_beat", 64'({dq_d0, dq_d1}), 64'({16'h1111, 16'h2222}));
            if (k == 3) check("mask_beat2", 64'({dm_d0, dm_d1}), 64'({2'b10, 2'b10}));
            if (k == 5) check("last_beat", 64'({dq_d0, dq_d1}), 64'({16'h7777, 16'h8888}));
        end
        check("single_drained", 64'(exp_q.size()), 64'(0));

        // Back-to-back: second start issued during POST
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_timing("b2b_a", k, 1, busy, wr_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, overrun, 1'b0);
            if (k == 6) start = 1'b1;
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_timing("b2b_b", k, 1, busy, wr_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, overrun, 1'b0);
        end

        // Overrun: start during DATA is ignored and flagged the next cycle
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = (k == 3);
            check_timing("ovr", k, 1, busy, wr_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, overrun, k == 4);
        end
        check("ovr_drained", 64'(exp_q.size()), 64'(0));

        // Write latency 3 on the second instance
        start2 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            check_timing("wl3", k, 3, busy_2, wr_ack_2, dq_oe_2, dqs_oe_2, dqs_d0_2, dqs_d1_2, overrun_2, 1'b0);
        end
        check("wl3_drained", 64'(exp2_q.size()), 64'(0));

        // Reset asserted in the middle of DATA
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_timing("prerst", k, 1, busy, wr_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, overrun, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({busy, wr_ack, dq_oe, dqs_oe, overrun}), 64'(0));
        check("midrst_dm", 64'({dm_d0, dm_d1}), 64'(4'hF));
        check("midrst_dq", 64'({dq_d0, dq_d1, dqs_d0, dqs_d1}), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        stim_q.delete();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("postrst_idle_k%0d", k), 64'({busy, wr_ack, dqs_oe}), 64'(0));
        end

        // Clean burst after reset recovery
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_timing("recover", k, 1, busy, wr_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, overrun, 1'b0);
        end
        check("final_drained", 64'(exp_q.size()), 64'(0));
        check("final_wl3_drained", 64'(exp2_q.size()), 64'(0));

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpdmc_ddr16_wrpath.md
Name: hpdmc_ddr16_wrpath

Overview:
Write-direction datapath for the DDR16 SDRAM PHY, the transmit counterpart of the IDDR2-based read capture. It accepts one 32-bit word per sys_clk from the controller and produces, per cycle, the rising-edge and falling-edge halves for the external ODDR2 primitives on DQ, DM and DQS. It also generates the DQ/DQS output enables with write latency, DQS preamble and postamble.

Parameters:
DQ_WIDTH, 16, SDRAM data pins; must be a multiple of 8.
BURST_WORDS, 4, sys_clk beats per write burst (DDR burst length = 2*BURST_WORDS); range 1..15.
WRITE_LATENCY, 1, sys_clk cycles from accepted start to the PRE state; range 1..7.

Ports:
sys_clk  in  1  system clock; all state on the rising edge.
sys_rst_n  in  1  asynchronous, active-low reset.
start  in  1  write command issued to SDRAM this cycle.
busy  out  1  high whenever the state is not IDLE.
overrun  out  1  one-cycle pulse when start is ignored.
wr_data  in  2*DQ_WIDTH  write word; upper half goes on the rising edge, lower half on the falling edge.
wr_mask  in  2*DQ_WIDTH/8  byte masks, split the same way as wr_data; 1 = masked.
wr_ack  out  1  wr_data/wr_mask sampled at this clock edge.
dq_d0  out  DQ_WIDTH  rising-edge DQ data to ODDR2.
dq_d1  out  DQ_WIDTH  falling-edge DQ data to ODDR2.
dm_d0  out  DQ_WIDTH/8  rising-edge DM.
dm_d1  out  DQ_WIDTH/8  falling-edge DM.
dqs_d0  out  DQ_WIDTH/8  rising-edge DQS level.
dqs_d1  out  DQ_WIDTH/8  falling-edge DQS level.
dq_oe  out  1  DQ/DM tristate enable (1 = drive).
dqs_oe  out  1  DQS tristate enable (1 = drive).

Behaviour:
- Clocking and reset:
  - Single clock sys_clk; reset sys_rst_n is asynchronous, active-low.
  - All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset values:
  - State = IDLE.
  - busy, overrun, wr_ack, dq_oe, dqs_oe = 0.
  - dq_d0/dq_d1 = 0; dm_d0/dm_d1 = all ones; dqs_d0/dqs_d1 = 0.
- States: IDLE, LAT, PRE, DATA, POST.
- Transitions:
  - IDLE + start: go to LAT if WRITE_LATENCY>1 (load latency counter with WRITE_LATENCY-2), otherwise go to PRE.
  - LAT: counts down; at 0 go to PRE.
  - PRE: lasts 1 cycle; dqs_oe=1, dqs_d0=dqs_d1=0 (preamble).
  - DATA: lasts BURST_WORDS cycles under a beat counter; dq_oe=1, dqs_oe=1, dqs_d0=all ones, dqs_d1=0.
  - POST: lasts 1 cycle; dqs_oe=1, dqs levels 0, dq_oe=0 (postamble).
  - POST with no start: go to IDLE.
  - POST + start: accepted; go to LAT/PRE exactly as from IDLE.
- Timing from start sampled at edge T:
  - PRE occupies cycle T+WRITE_LATENCY.
  - DATA occupies cycles T+WRITE_LATENCY+1 .. T+WRITE_LATENCY+BURST_WORDS.
  - POST occupies the next cycle.
- Data handshake:
  - wr_ack is high during PRE and during the first BURST_WORDS-1 DATA cycles, i.e. BURST_WORDS consecutive cycles.
  - The word sampled with wr_ack in cycle k appears on dq_d0/dq_d1/dm_d0/dm_d1 in cycle k+1.
  - Upstream must hold valid data whenever wr_ack is high; there is no stall. wr_ack is never high in any other state.
- Idle data values: outside DATA, dq_d* = 0 and dm_d* = all ones.
- Ignored start:
  - start in LAT, PRE or DATA is ignored; overrun pulses high for 1 cycle the following cycle.
  - The burst in progress is unaffected.
- Reset mid-burst: immediate asynchronous return to reset values; the partial burst is abandoned and no further wr_ack is issued.

Test Plan:
1. Reset: assert sys_rst_n=0 mid-DATA -> same cycle busy=0, dq_oe=0, dqs_oe=0, wr_ack=0, dm_d0=dm_d1=2'b11; after release, stays IDLE until start.
2. Single burst, defaults: start at T=10, data words 0x11112222, 0x33334444, 0x55556666, 0x77778888 given on ack cycles ->
   - wr_ack high cycles 11..14; PRE at 11; DATA 12..15; POST 16; busy 0 at 17.
   - dq_d0/dq_d1 at 12 = 0x1111/0x2222, at 15 = 0x7777/0x8888.
   - dqs_d0=2'b11 in 12..15; dqs_oe 11..16; dq_oe 12..15.
3. Latency: WRITE_LATENCY=3, start at T=0 -> LAT cycles 1..2, PRE 3, first data beat on dq at 4, POST at 8.
4. Masks: wr_mask=4'b1010 on beat 2 -> dm_d0=2'b10, dm_d1=2'b10 on that beat's DATA cycle; all other DATA beats follow the input masks; outside DATA dm=2'b11.
5. Back-to-back: start during POST (cycle 16 in scenario 2) -> no IDLE cycle; PRE at 17, DATA 18..21, dqs_oe continuous 11..22.
6. Overrun: start during DATA at cycle 13 -> overrun=1 at 14 only; burst completes unchanged; busy drops at 17.
